// File: rtl/cluster_collector.sv
// cluster_collector
// Per-frame cluster accumulator downstream of the 768-pad priority encoder.
// Candidates accepted between two frame_strobe pulses are stored in arrival
// order and published as a packed, registered frame of 14-bit words
// {cnt[2:0], adr[10:0]} on the following strobe.
// Optional feature macro: CLUSTER_COLLECTOR_DEDUP_EN (drops a candidate whose
// address repeats the last accepted address of the current frame).
module cluster_collector #(
  parameter int          MXCLUSTERS  = 8,
  parameter int          MXADR       = 1536,
  parameter logic [10:0] INVALID_ADR = 11'h7FF
) (
  input  logic                     clock,
  input  logic                     global_reset,
  input  logic                     frame_strobe,
  input  logic                     cluster_found,
  input  logic [10:0]              adr,
  input  logic [2:0]               cnt,
  output logic [MXCLUSTERS*14-1:0] clusters_out,
  output logic [3:0]               cluster_count,
  output logic                     overflow,
  output logic                     bad_adr,
  output logic                     frame_valid
);

  localparam int              FRAME_W     = MXCLUSTERS * 14;
  localparam logic [13:0]     EMPTY_WORD  = {3'd0, INVALID_ADR};
  localparam logic [3:0]      MAX_COUNT   = 4'(MXCLUSTERS);
  localparam logic [11:0]     ADR_LIMIT   = 12'(MXADR);
  localparam logic [FRAME_W-1:0] EMPTY_FRAME = {MXCLUSTERS{EMPTY_WORD}};

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  state_t               state_q, state_d;

  // working frame being collected
  logic [FRAME_W-1:0]   work_q, work_d;
  logic [3:0]           count_q, count_d;
  logic                 ovf_q, ovf_d;
  logic                 bad_q, bad_d;
  logic [10:0]          last_q, last_d;

  // published frame
  logic [FRAME_W-1:0]   out_words_q, out_words_d;
  logic [3:0]           out_count_q, out_count_d;
  logic                 out_ovf_q, out_ovf_d;
  logic                 out_bad_q, out_bad_d;
  logic                 fv_q, fv_d;

  logic                 legal_s;
  logic                 illegal_s;
  logic                 dup_s;

  // classify the incoming candidate against the address range
  always_comb begin
    legal_s   = 1'b0;
    illegal_s = 1'b0;
    if (cluster_found) begin
      if ({1'b0, adr} < ADR_LIMIT) begin
        legal_s = 1'b1;
      end else begin
        illegal_s = 1'b1;
      end
    end else begin
      legal_s   = 1'b0;
      illegal_s = 1'b0;
    end
  end

  // next-state logic: arming, publishing and candidate accumulation
  always_comb begin
    state_d     = state_q;
    work_d      = work_q;
    count_d     = count_q;
    ovf_d       = ovf_q;
    bad_d       = bad_q;
    last_d      = last_q;
    out_words_d = out_words_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    out_bad_d   = out_bad_q;
    fv_d        = 1'b0;
    dup_s       = 1'b0;

    case (state_q)
      IDLE: begin
        // the first strobe only arms collection; nothing is published
        if (frame_strobe) begin
          state_d = COLLECT;
          work_d  = EMPTY_FRAME;
          count_d = 4'd0;
          ovf_d   = 1'b0;
          bad_d   = 1'b0;
          last_d  = INVALID_ADR;
        end else begin
          state_d = IDLE;
        end
      end

      COLLECT: begin
        state_d = COLLECT;
        // publish the finished frame and start a fresh working set; a
        // candidate arriving with the strobe lands in the fresh set below
        if (frame_strobe) begin
          out_words_d = work_q;
          out_count_d = count_q;
          out_ovf_d   = ovf_q;
          out_bad_d   = bad_q;
          fv_d        = 1'b1;
          work_d      = EMPTY_FRAME;
          count_d     = 4'd0;
          ovf_d       = 1'b0;
          bad_d       = 1'b0;
          last_d      = INVALID_ADR;
        end else begin
          fv_d = 1'b0;
        end

`ifdef CLUSTER_COLLECTOR_DEDUP_EN
        dup_s = (adr == last_d);
`else
        dup_s = 1'b0;
`endif

        if (illegal_s) begin
          bad_d = 1'b1;
        end else if (legal_s && !dup_s) begin
          last_d = adr;
          if (count_d < MAX_COUNT) begin
            for (int i = 0; i < MXCLUSTERS; i++) begin
              if (count_d == 4'(i)) begin
                work_d[i*14 +: 14] = {cnt, adr};
              end else begin
                work_d[i*14 +: 14] = work_d[i*14 +: 14];
              end
            end
            count_d = count_d + 4'd1;
          end else begin
            ovf_d = 1'b1;
          end
        end else begin
          last_d = last_d;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // state and output registers with synchronous reset
  always_ff @(posedge clock) begin
    if (global_reset) begin
      state_q     <= IDLE;
      work_q      <= EMPTY_FRAME;
      count_q     <= 4'd0;
      ovf_q       <= 1'b0;
      bad_q       <= 1'b0;
      last_q      <= INVALID_ADR;
      out_words_q <= EMPTY_FRAME;
      out_count_q <= 4'd0;
      out_ovf_q   <= 1'b0;
      out_bad_q   <= 1'b0;
      fv_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      count_q     <= count_d;
      ovf_q       <= ovf_d;
      bad_q       <= bad_d;
      last_q      <= last_d;
      out_words_q <= out_words_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
      out_bad_q   <= out_bad_d;
      fv_q        <= fv_d;
    end
  end

  assign clusters_out  = out_words_q;
  assign cluster_count = out_count_q;
  assign overflow      = out_ovf_q;
  assign bad_adr       = out_bad_q;
  assign frame_valid   = fv_q;

endmodule

// File: tb/tb_cluster_collector.sv
// Self-checking bench for cluster_collector: directed scenarios plus random
// traffic, compared every cycle against a queue-based frame model.
module tb_cluster_collector;

  localparam int MX = 8;
  localparam int LIMIT = 1536;

  logic            clock;
  logic            global_reset;
  logic            frame_strobe;
  logic            cluster_found;
  logic [10:0]     adr;
  logic [2:0]      cnt;
  logic [MX*14-1:0] clusters_out;
  logic [3:0]      cluster_count;
  logic            overflow;
  logic            bad_adr;
  logic            frame_valid;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  cluster_collector #(.MXCLUSTERS(MX), .MXADR(LIMIT), .INVALID_ADR(11'h7FF)) dut (
    .clock(clock), .global_reset(global_reset), .frame_strobe(frame_strobe),
    .cluster_found(cluster_found), .adr(adr), .cnt(cnt),
    .clusters_out(clusters_out), .cluster_count(cluster_count),
    .overflow(overflow), .bad_adr(bad_adr), .frame_valid(frame_valid)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- behavioural model ----------------
  bit          armed;
  int          wq[$];
  bit          m_ovf, m_bad;
  int          m_last;
  logic [13:0] exp_w[MX];
  int          exp_count;
  bit          exp_ovf, exp_bad, exp_fv;

  function automatic bit dedup_on();
`ifdef CLUSTER_COLLECTOR_DEDUP_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic clear_work();
    wq.delete();
    m_ovf = 0;
    m_bad = 0;
    m_last = -1;
  endtask

  task automatic model_update(input bit r, input bit s, input bit f, input int a, input int c);
    exp_fv = 0;
    if (r) begin
      armed = 0;
      clear_work();
      for (int i = 0; i < MX; i++) exp_w[i] = 14'h07FF;
      exp_count = 0; exp_ovf = 0; exp_bad = 0;
      return;
    end
    if (!armed) begin
      if (s) begin
        armed = 1;
        clear_work();
      end
      return;
    end
    if (s) begin
      for (int i = 0; i < MX; i++) exp_w[i] = (i < wq.size()) ? 14'(wq[i]) : 14'h07FF;
      exp_count = wq.size();
      exp_ovf = m_ovf;
      exp_bad = m_bad;
      exp_fv = 1;
      clear_work();
    end
    if (f) begin
      if (a >= LIMIT) m_bad = 1;
      else if (dedup_on() && a == m_last) begin end
      else begin
        m_last = a;
        if (wq.size() < MX) wq.push_back(c * 2048 + a);
        else m_ovf = 1;
      end
    end
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // per-cycle comparison of every output against the model
  always @(negedge clock) begin
    if (chk_en) begin
      for (int i = 0; i < MX; i++) check($sformatf("slot%0d", i), clusters_out[i*14 +: 14], exp_w[i]);
      check("cluster_count", cluster_count, exp_count);
      check("overflow", overflow, exp_ovf);
      check("bad_adr", bad_adr, exp_bad);
      check("frame_valid", frame_valid, exp_fv);
    end
  end

  task automatic step(input bit r, input bit s, input bit f, input int a, input int c);
    global_reset  = r;
    frame_strobe  = s;
    cluster_found = f;
    adr           = 11'(a);
    cnt           = 3'(c);
    @(posedge clock);
    model_update(r, s, f, a, c);
    @(negedge clock);
  endtask

  task automatic cand(input int a, input int c);
    step(0, 0, 1, a, c);
  endtask

  task automatic strobe();
    step(0, 1, 0, 0, 0);
  endtask

  logic [MX*14-1:0] empty_frame;

  initial begin
    empty_frame = {MX{14'h07FF}};
    global_reset = 1'b1; frame_strobe = 1'b0; cluster_found = 1'b0; adr = 11'd0; cnt = 3'd0;

    // reset test
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0);
    chk_en = 1;
    check("rst_count_lit", cluster_count, 0);
    check("rst_fv_lit", frame_valid, 0);
    check("rst_words_lit", clusters_out, empty_frame);
    strobe();
    check("arm_no_fv_lit", frame_valid, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0);
    strobe();
    check("empty_fv_lit", frame_valid, 1);
    check("empty_count_lit", cluster_count, 0);
    check("empty_words_lit", clusters_out, empty_frame);
    step(0, 0, 0, 0, 0);
    check("fv_pulse_lit", frame_valid, 0);

    // ordered fill
    cand(5, 2); cand(300, 0); cand(767, 7);
    strobe();
    check("fill_s0_lit", clusters_out[13:0], 14'h1005);
    check("fill_s1_lit", clusters_out[27:14], 14'h012C);
    check("fill_s2_lit", clusters_out[41:28], 14'h3AFF);
    check("fill_s7_lit", clusters_out[111:98], 14'h07FF);
    check("fill_count_lit", cluster_count, 3);
    check("fill_ovf_lit", overflow, 0);

    // overflow
    for (int i = 0; i < 10; i++) cand(i, 0);
    strobe();
    check("ovf_count_lit", cluster_count, 8);
    check("ovf_flag_lit", overflow, 1);
    check("ovf_s7_lit", clusters_out[111:98], 14'h0007);
    strobe();
    check("ovf_clear_lit", overflow, 0);

    // range check
    cand(1536, 0); cand(12, 0);
    strobe();
    check("range_s0_lit", clusters_out[10:0], 12);
    check("range_count_lit", cluster_count, 1);
    check("range_bad_lit", bad_adr, 1);

    // simultaneous strobe and candidate
    cand(50, 1);
    step(0, 1, 1, 40, 3);
    check("simul_old_count_lit", cluster_count, 1);
    check("simul_old_s0_lit", clusters_out[10:0], 50);
    strobe();
    check("simul_new_s0_lit", clusters_out[13:0], 14'h1828);
    check("simul_new_count_lit", cluster_count, 1);

    // dedup
    cand(100, 0); cand(100, 0); cand(100, 0); cand(101, 0); cand(100, 0);
    strobe();
`ifdef CLUSTER_COLLECTOR_DEDUP_EN
    check("dedup_count_lit", cluster_count, 3);
    check("dedup_s1_lit", clusters_out[27:14], 101);
`else
    check("dedup_count_lit", cluster_count, 5);
    check("dedup_s1_lit", clusters_out[27:14], 100);
`endif

    // reset mid-frame discards the partial frame
    cand(7, 1); cand(8, 1);
    step(1, 1, 1, 9, 0);
    strobe();
    check("midrst_no_fv_lit", frame_valid, 0);
    cand(20, 0);
    strobe();
    check("midrst_count_lit", cluster_count, 1);
    check("midrst_s0_lit", clusters_out[13:0], 14'h0014);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      int a;
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 5) a = $urandom_range(0, 3);
      else if (sel < 8) a = $urandom_range(0, 1535);
      else a = $urandom_range(1530, 2047);
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) == 0),
           ($urandom_range(0, 2) != 0), a, $urandom_range(0, 7));
    end

    chk_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cluster_collector.md
# cluster_collector

Per-bunch-crossing cluster accumulator sitting directly downstream of the 768-pad priority encoder. Each clock it samples the encoder's `cluster_found`/`adr`/`cnt` triplet. Within the frame bounded by two consecutive `frame_strobe` pulses, it stores up to MXCLUSTERS accepted clusters in arrival order. On the next strobe it publishes them as a packed, registered frame of 14-bit cluster words for the trigger-link formatter.

## Interface

Parameters:
- MXCLUSTERS, 8: cluster slots per frame (1..15).
- MXADR, 1536: first illegal address; candidates with adr >= MXADR are rejected.
- INVALID_ADR, 11'h7FF: address field of an empty slot.

Ports:
- clock  in  1  system clock; all logic on posedge.
- global_reset  in  1  synchronous, active-high reset.
- frame_strobe  in  1  one-cycle pulse marking the first candidate cycle of a new frame.
- cluster_found  in  1  candidate valid from the encoder.
- adr  in  11  candidate pad address.
- cnt  in  3  candidate cluster size minus one.
- clusters_out  out  MXCLUSTERS*14  slot i at bits [i*14+13:i*14], formatted {cnt[2:0], adr[10:0]}.
- cluster_count  out  4  number of valid slots in the published frame.
- overflow  out  1  the published frame had more accepted candidates than MXCLUSTERS.
- bad_adr  out  1  the published frame saw at least one out-of-range candidate.
- frame_valid  out  1  one-cycle pulse when the published outputs update.

## Operation

- FSM states:
  - IDLE, entered on reset. Candidates are ignored. frame_strobe moves the FSM to COLLECT; no frame is published on that strobe.
  - COLLECT. Candidates are accepted. frame_strobe publishes the current frame and restarts collection.
- Acceptance rule in COLLECT: accept when cluster_found=1, adr < MXADR, and the dedup check passes (see Configuration).
- Dedup comparison register: holds the last accepted address; cleared to invalid at every frame start.
- Accepted candidate while working count < MXCLUSTERS:
  - written to slot[count];
  - count increments.
- Accepted candidate while working count = MXCLUSTERS: dropped, and the working overflow flag is set. Count saturates at MXCLUSTERS.
- cluster_found=1 with adr >= MXADR: not stored, does not update the dedup register, and sets the working bad_adr flag.
- Working slots reset to {3'd0, INVALID_ADR} at every frame start, so unused slots always publish as invalid words.
- Publish on frame_strobe in COLLECT:
  - copy working slots, count, overflow and bad_adr into the output registers;
  - pulse frame_valid.
- Strobe coinciding with a candidate: the candidate belongs to the new frame. It is written to slot 0 of the fresh working set, with count=1, in the same clock as the old frame is copied out.
- Back-to-back strobes: this is legal. The published frame is empty (count 0, all invalid words).
- Width rule: cluster_count is 4 bits; the maximum published value is MXCLUSTERS.

## Timing

- Reset values:
  - every clusters_out word = {3'd0, INVALID_ADR};
  - cluster_count = 0;
  - overflow = 0;
  - bad_adr = 0;
  - frame_valid = 0;
  - FSM state = IDLE;
  - working state cleared.
- Reset mid-frame: the partial frame is discarded and nothing is published. The first strobe after reset only arms COLLECT.
- Latency: outputs and frame_valid are registered and change on the clock edge after the sampled frame_strobe (1 cycle).
- Outputs hold their values between frame_valid pulses.
- Candidates are sampled on the same edge as frame_strobe. There is no input pipelining; the upstream encoder outputs are combinational from its stage-3 register.
- Reset has priority over frame_strobe and candidates in the same cycle.

## Configuration

- CLUSTER_COLLECTOR_DEDUP_EN defined:
  - a candidate whose adr equals the last accepted adr in the current frame is silently dropped;
  - dropped duplicates do not count toward overflow;
  - this covers an encoder that re-presents an unmasked cluster on consecutive cycles.
- CLUSTER_COLLECTOR_DEDUP_EN undefined: the comparator is absent and every legal candidate is accepted, including repeats.

## Test plan

- Reset test:
  - stimulus: assert global_reset for 3 cycles, then strobe, then 4 idle cycles, then strobe;
  - required response: no frame_valid on the first strobe; on the second, frame_valid=1 one cycle later with count=0 and all words 14'h07FF.
- Ordered fill:
  - stimulus: strobe, then candidates (adr 5, cnt 2), (adr 300, cnt 0), (adr 767, cnt 7), then strobe;
  - required response: slot0=14'h1005, slot1=14'h012C, slot2=14'h3AFF, slots 3..7 invalid, count=3, overflow=0.
- Overflow:
  - stimulus: 10 distinct legal candidates (adr 0..9) in one frame;
  - required response: slots hold adr 0..7, count=8, overflow=1; the next empty frame publishes overflow=0.
- Range check:
  - stimulus: candidate adr 1536 followed by adr 12;
  - required response: slot0 adr=12, count=1, bad_adr=1.
- Simultaneous strobe and candidate:
  - stimulus: candidate adr 40 arriving with strobe;
  - required response: the old frame publishes without adr 40; the next frame has slot0 adr=40.
- Dedup (macro defined):
  - stimulus: adr 100 for 3 consecutive cycles, then adr 101, then adr 100;
  - required response: count=3 with slots 100, 101, 100.
  - With the macro undefined, the same stimulus gives count=5.
